// File: rtl/freq_counter_core.sv
// Gated edge counter: synchronises one selected asynchronous input and counts
// its rising edges over a window of exactly cycle_count clocks.
module freq_counter_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int NINPUTS     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] cycle_count,
  input  logic [DATA_WIDTH-1:0] input_select,
  input  logic [NINPUTS-1:0]    sig_in,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] edge_count,
  output logic                  busy
);

  localparam int SELW = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
  localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0]  win_q, win_d;
  logic [DATA_WIDTH-1:0]  win_cnt_q, win_cnt_d;
  logic [2:0]             arm_cnt_q, arm_cnt_d;
  logic [DATA_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
  logic [DATA_WIDTH-1:0]  edge_count_q, edge_count_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  logic                   mux_bit;
  logic                   rise;
  logic                   start;
  logic [DATA_WIDTH-1:0]  edge_inc;

  // Out-of-range selects read a constant 0 so the measurement reports nothing.
  always_comb begin
    mux_bit = 1'b0;
    if (sel_q < DATA_WIDTH'(NINPUTS))
      mux_bit = sig_in[sel_q[SELW-1:0]];
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign start    = enable & ((state_q == IDLE) | (state_q == DONE));
  assign edge_inc = (edge_cnt_q == '1) ? edge_cnt_q : edge_cnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      win_q        <= '0;
      win_cnt_q    <= '0;
      arm_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      edge_count_q <= '0;
      sync_q       <= '0;
      hist_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      win_q        <= win_d;
      win_cnt_q    <= win_cnt_d;
      arm_cnt_q    <= arm_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      edge_count_q <= edge_count_d;
      sync_q       <= sync_d;
      hist_q       <= hist_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    win_d        = win_q;
    win_cnt_d    = win_cnt_q;
    arm_cnt_d    = arm_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    edge_count_d = edge_count_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], mux_bit};
    hist_d       = sync_q[SYNC_STAGES-1];
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = ARM;
          sel_d      = input_select;
          win_d      = cycle_count;
          edge_cnt_d = '0;
          arm_cnt_d  = '0;
        end
      end
      // ARM lets the chain and history flop fill with the new selection so a
      // level held from before the start cannot look like a fresh edge.
      ARM: begin
        arm_cnt_d = arm_cnt_q + 3'd1;
        if (arm_cnt_q == ARM_LAST) begin
          if (win_q == '0) begin
            state_d      = DONE;
            edge_count_d = '0;
          end else begin
            state_d   = COUNT;
            win_cnt_d = win_q;
          end
        end
      end
      COUNT: begin
        if (rise) edge_cnt_d = edge_inc;
        win_cnt_d = win_cnt_q - 1'b1;
        if (win_cnt_q == DATA_WIDTH'(1)) begin
          state_d      = DONE;
          edge_count_d = rise ? edge_inc : edge_cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ARM) | (state_q == COUNT);
    done = (state_q == DONE);
  end

  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_freq_counter_core.sv
// Randomised scoreboard bench for freq_counter_core: expected edge counts come
// from the sampled history of the selected input over the gate window.
module tb_freq_counter_core;
  localparam int DW = 32;
  localparam int NI = 8;
  localparam int S  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] cycle_count = '0;
  logic [DW-1:0] input_select = '0;
  logic [NI-1:0] sig_in = '0;
  logic          done;
  logic [DW-1:0] edge_count;
  logic          busy;

  freq_counter_core #(.DATA_WIDTH(DW), .NINPUTS(NI), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cycle_count(cycle_count),
    .input_select(input_select), .sig_in(sig_in), .done(done),
    .edge_count(edge_count), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {int t; int win; int sel;} run_t;
  run_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [NI-1:0] samp [int];
  int half [NI];
  int ph [NI];
  bit rnd_mode = 0;
  bit prev_done = 0;
  longint last_res = 0;
  longint res2 = -1;
  longint last_pop = -1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Record what the DUT's mux input saw at each rising edge.
  always @(posedge clock) begin
    samp[cyc] = sig_in;
    cyc++;
  end

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (rnd_mode) sig_in[i] = 1'($urandom);
      else if (ph[i] >= half[i] - 1) begin ph[i] = 0; sig_in[i] = ~sig_in[i]; end
      else ph[i]++;
    end
  end

  function automatic bit xbit(input int j, input int sel);
    if (sel >= NI) return 1'b0;
    return samp[j][sel];
  endfunction

  // Monitor: pops one descriptor per rising edge of done.
  always @(negedge clock) begin
    if (!reset) begin
      if (busy) chk(edge_count == DW'(last_res), "hold_during_run", edge_count, last_res);
      if (busy && done) chk(0, "busy_and_done", 1, 0);
      if (done && !prev_done) begin
        if (q.size() == 0) chk(0, "spurious_done", 1, 0);
        else begin
          run_t d;
          int ev;
          longint exp;
          d = q.pop_front();
          ev = cyc - 1;
          chk(ev == d.t + S + 2 + d.win, "done_latency", ev - d.t, S + 2 + d.win);
          exp = 0;
          for (int j = d.t + 2; j <= d.t + 1 + d.win; j++)
            if (!xbit(j, d.sel) && xbit(j + 1, d.sel)) exp++;
          chk(edge_count == DW'(exp), "edge_count", edge_count, exp);
          last_res = exp;
          last_pop = edge_count;
        end
      end
      prev_done = done;
    end else prev_done = 0;
  end

  task automatic start_run(input int sel, input int win);
    run_t d;
    @(negedge clock);
    enable = 1'b1;
    input_select = DW'(sel);
    cycle_count = DW'(win);
    d.t = cyc; d.win = win; d.sel = sel;
    q.push_back(d);
    @(negedge clock);
    enable = 1'b0;
    chk(done == 1'b0 && busy == 1'b1, "start_drops_done", {done, busy}, 2'b01);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin @(negedge clock); n++; end
    if (q.size() != 0) begin
      chk(0, "timeout", n, limit);
      q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin half[i] = $urandom_range(2, 9); ph[i] = 0; end
    half[3] = 5;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // 1: idle after reset
    repeat (10) @(negedge clock);
    chk(done == 0 && busy == 0 && edge_count == 0, "reset_idle", {done, busy, edge_count}, 0);

    // 2: clock/10 on input 3
    start_run(3, 1000);
    wait_idle(1100);
    res2 = last_pop;
    chk(res2 >= 99 && res2 <= 101, "div10_count", res2, 100);

    // 3: zero window, and single-cycle window
    start_run(3, 0);
    wait_idle(20);
    start_run(3, 1);
    wait_idle(20);

    // 4: out-of-range select with everything toggling
    for (int i = 0; i < NI; i++) half[i] = (i % 3) + 2;
    half[3] = 5;
    start_run(9, 500);
    wait_idle(600);
    chk(last_pop == 0, "sel_oob_zero", last_pop, 0);

    // 5: ignored mid-run enable, then a new run
    start_run(3, 1000);
    repeat (500) @(negedge clock);
    enable = 1'b1; input_select = 5; cycle_count = 7;
    @(negedge clock);
    enable = 1'b0;
    wait_idle(1100);
    chk(last_pop == res2, "ignored_enable", last_pop, res2);
    start_run(5, 300);
    wait_idle(400);

    // 6: reset mid-window, then a full measurement
    start_run(3, 1000);
    repeat (S + 400) @(negedge clock);
    reset = 1'b1;
    #1;
    chk(done == 0 && busy == 0 && edge_count == 0, "reset_mid_run", {done, busy, edge_count}, 0);
    q.delete();
    last_res = 0;
    @(negedge clock);
    reset = 1'b0;
    start_run(3, 1000);
    wait_idle(1100);
    chk(last_pop == res2, "after_reset", last_pop, res2);

    // Random runs, square waves and per-cycle noise
    for (int r = 0; r < 16; r++) begin
      rnd_mode = (r % 4 == 3);
      start_run($urandom_range(0, 11), $urandom_range(0, 80));
      wait_idle(200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1);
  end
endmodule
